// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: show-ahead circular buffer of {data, shift, dir} commands feeding a barrel shifter
module shift_cmd_queue #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SHIFT_W-1:0]         in_shift,
    input  logic                       in_dir,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [SHIFT_W-1:0]         out_shift,
    output logic                       out_dir,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + SHIFT_W + 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    assign in_ready  = count != FULL;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Empty queue presents zeros so the shifter sees a quiet input
    assign {out_data, out_shift, out_dir} = out_valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_data, in_shift, in_dir};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
endmodule

// File: tb/tb_shift_cmd_queue.sv
// tb_shift_cmd_queue: directed scenario tests for shift_cmd_queue
module tb_shift_cmd_queue;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0, in_ready, in_dir = 0;
    logic [7:0] in_data = 0, out_data;
    logic [2:0] in_shift = 0, out_shift;
    logic       out_valid, out_ready = 0, out_dir;
    logic [2:0] count;
    int tests = 0, fails = 0;

    shift_cmd_queue #(.DATA_W(8), .SHIFT_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .out_dir(out_dir), .count(count)
    );

    always #5 clk = ~clk;

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic dr, input logic r);
        in_valid = v; in_data = d; in_shift = s; in_dir = dr; out_ready = r;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if ({out_data, out_shift, out_dir} !== 12'h0) begin fails++; $display("FAIL reset_out_fields got %h exp 000", {out_data, out_shift, out_dir}); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single;
        step(1, 8'hAA, 3'd3, 0, 0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid); end
        tests++; if ({out_data, out_shift, out_dir} !== {8'hAA, 3'd3, 1'b0}) begin fails++; $display("FAIL single_fields got %h/%0d/%b exp aa/3/0", out_data, out_shift, out_dir); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
        step(0, 0, 0, 0, 1);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
        tests++; if ({out_data, out_shift, out_dir} !== 12'h0) begin fails++; $display("FAIL single_pop_fields got %h exp 000", {out_data, out_shift, out_dir}); end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 3'(i), i[0], 0);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
        step(1, 8'h05, 3'd5, 1, 0);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_overflow_count got %0d exp 4", count); end
        for (int i = 1; i <= 4; i++) begin
            tests++; if ({out_data, out_shift} !== {8'(i), 3'(i)}) begin fails++; $display("FAIL fill_drain_%0d got %h/%0d exp %h/%0d", i, out_data, out_shift, i, i); end
            step(0, 0, 0, 0, 1);
        end
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL fill_drained got count %0d valid %b exp 0/0", count, out_valid); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 3'd1, 0, 0);
        step(1, 8'h14, 3'd1, 0, 1);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_pop_count got %0d exp 3", count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready got %b exp 1", in_ready); end
        for (int i = 1; i <= 3; i++) begin
            tests++; if (out_data !== 8'h10 + 8'(i)) begin fails++; $display("FAIL full_pop_drain_%0d got %h exp %h", i, out_data, 8'h10 + 8'(i)); end
            step(0, 0, 0, 0, 1);
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_pop_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        step(1, 8'h20, 3'd2, 1, 0);
        step(1, 8'h21, 3'd2, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tests++; if (out_data !== 8'h20 + 8'(i)) begin fails++; $display("FAIL b2b_head_%0d got %h exp %h", i, out_data, 8'h20 + 8'(i)); end
            step(1, 8'h22 + 8'(i), 3'd2, 1, 1);
            tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count_%0d got %0d exp 2", i, count); end
        end
        for (int i = 0; i < 2; i++) begin
            tests++; if (out_data !== 8'h28 + 8'(i)) begin fails++; $display("FAIL b2b_tail_%0d got %h exp %h", i, out_data, 8'h28 + 8'(i)); end
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_stall;
        step(1, 8'h81, 3'd7, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(i < 2, 8'h90 + 8'(i), 3'd0, 0, 0);
            tests++; if ({out_data, out_shift, out_dir} !== {8'h81, 3'd7, 1'b1}) begin fails++; $display("FAIL stall_hold_%0d got %h/%0d/%b exp 81/7/1", i, out_data, out_shift, out_dir); end
        end
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL stall_count got %0d exp 3", count); end
    endtask

    task automatic test_reset_mid;
        rst_n = 0;
        #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL rstmid_count got %0d exp 0", count); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_flags got valid %b ready %b exp 0/1", out_valid, in_ready); end
        tests++; if ({out_data, out_shift, out_dir} !== 12'h0) begin fails++; $display("FAIL rstmid_fields got %h exp 000", {out_data, out_shift, out_dir}); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        step(1, 8'h5A, 3'd2, 1, 0);
        tests++; if ({out_data, out_shift, out_dir} !== {8'h5A, 3'd2, 1'b1} || count !== 3'd1) begin fails++; $display("FAIL rstmid_first got %h/%0d/%b count %0d exp 5a/2/1 count 1", out_data, out_shift, out_dir, count); end
        step(0, 0, 0, 0, 1);
        tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL rstmid_no_stale got valid %b count %0d exp 0/0", out_valid, count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill;
        test_full_pop;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_cmd_queue.md
# shift_cmd_queue

Buffers shift commands (data word, shift amount, direction) ahead of the combinational barrel shifter. Accepts commands on a valid/ready handshake from the producer and presents the oldest command show-ahead on its output fields, which connect directly to the barrel shifter's data_in/shift/dir inputs. It decouples a bursty command source from a consumer that may stall, and exposes fill level for flow control.

## Interface
Parameters:
- DATA_W, 8, data word width. Must be a power of two, at least 2.
- SHIFT_W, 3, shift amount width. Equals log2(DATA_W).
- DEPTH, 4, queue entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a command on in_data/in_shift/in_dir.
- in_ready  output  1  queue can accept a command this cycle.
- in_data  input  DATA_W  data word to be shifted.
- in_shift  input  SHIFT_W  shift amount, 0 to DATA_W-1.
- in_dir  input  1  direction: 0 = left, 1 = right.
- out_valid  output  1  head command present on the out_* fields.
- out_ready  input  1  consumer takes the head command this cycle.
- out_data  output  DATA_W  head data word, to barrel shifter data_in.
- out_shift  output  SHIFT_W  head shift amount, to barrel shifter shift.
- out_dir  output  1  head direction, to barrel shifter dir.
- count  output  log2(DEPTH)+1  number of stored entries, 0 to DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry is {data, shift, dir}, DATA_W+SHIFT_W+1 bits wide.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, plus a registered count.
- Pointers wrap from DEPTH-1 to 0 with no special case.
- push = in_valid && in_ready. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = out_valid && out_ready. On pop, rd_ptr increments.
- Count update: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged; neither leaves count unchanged.
- in_ready = (count != DEPTH). It is derived from registered state only and never depends combinationally on in_valid or out_ready.
- out_valid = (count != 0).
- Show-ahead: out_data/out_shift/out_dir are the entry at rd_ptr whenever out_valid = 1.
- When count = 0, out_data, out_shift and out_dir are driven to 0. The downstream shifter therefore sees a quiet, deterministic input.
- Full (count = DEPTH): in_ready = 0. in_valid is ignored and is not an error. A pop in that cycle frees a slot, but in_ready only rises in the next cycle.
- Empty (count = 0): out_ready is ignored. There is no bypass: a command pushed into an empty queue is not visible in the same cycle.
- Stability: while out_valid = 1 and out_ready = 0, the out_* fields hold their value.
- The block does no range checking on in_shift. Every SHIFT_W value is legal.
- Reset asserted at any time, including mid-burst: count = 0, wr_ptr = rd_ptr = 0, and all stored entries are discarded. Memory contents need not be cleared.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_shift = 0, out_dir = 0, count = 0.
- Latency: a command pushed at edge N appears on out_* with out_valid = 1 after edge N.
- Throughput: one push and one pop per cycle, sustained, for any count from 1 to DEPTH-1.
- The out_* fields change only after a clock edge, or asynchronously on rst_n assertion.
- Release of rst_n is synchronised by the system. The first push may occur on the first edge after release.

## Test plan
- Reset, then push {8'hAA, 3, 0} -> next cycle out_valid = 1, out_data = AA, out_shift = 3, out_dir = 0, count = 1. Pop with out_ready = 1 -> out_valid = 0, out_* = 0.
- Fill: push 4 commands with data 01, 02, 03, 04 and out_ready = 0 -> count = 4 and in_ready = 0. A fifth push of data 05 is not stored. Draining yields 01, 02, 03, 04 only.
- Simultaneous push/pop at count = 2 for 8 cycles -> count stays 2 and the output order matches the input order. Run long enough for the pointers to wrap at least twice.
- Full with pop and in_valid = 1 in the same cycle -> no push that cycle, count = 3. in_ready = 1 on the next cycle.
- Stall: head {8'h81, 7, 1} with out_ready = 0 for 5 cycles while 2 more commands are pushed -> out_* hold 81/7/1 throughout and count rises to 3.
- Assert rst_n = 0 mid-burst at count = 3 -> immediately count = 0, out_valid = 0, in_ready = 1. After release, a new push is output first, with no stale data.
